reg_bank_sv: RTL and testbench

Scalar and vector register bank at the write end of the MEM/WB pipeline register. It holds 32 scalar registers (N bits) and 32 vector registers (V lanes of L bits). It commits the writeback stage's WD3 results, selected by WE, A3 and OpType, and serves two combinational read ports to decode with same-cycle write-through bypass. An internal pending-write scoreboard lets decode detect RAW hazards against in-flight destinations.

---
 rtl/reg_bank_sv_pkg.sv | 27 ++
 rtl/reg_bank_sv_if.sv | 40 ++++
 rtl/reg_bank_sv_scoreboard.sv | 71 +++++++
 rtl/reg_bank_sv.sv | 80 ++++++++
 tb/tb_reg_bank_sv.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/reg_bank_sv_pkg.sv
// Shared types and constants for the scalar/vector register bank.
// OpType encodings, file geometry and the packed vector register type.
package reg_bank_sv_pkg;

  localparam int N  = 32;
  localparam int L  = 8;
  localparam int V  = 20;
  localparam int R  = 32;
  localparam int AW = 5;

  typedef enum logic [1:0] {
    OP_SS   = 2'b00,
    OP_VV   = 2'b01,
    OP_VS   = 2'b10,
    OP_NONE = 2'b11
  } op_e;

  typedef logic [V-1:0][L-1:0] vec_t;

  function automatic logic is_vec_op(input logic [1:0] op);
    case (op)
      OP_VV, OP_VS: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/reg_bank_sv_if.sv
// Writeback, decode-read and scoreboard signals of the register bank.
// The slave modport is the bank itself; master is the pipeline driving it.
interface reg_bank_sv_if;
  import reg_bank_sv_pkg::*;

  logic             enable_i;
  logic             RegFile_WE_i;
  logic [AW-1:0]    A3_i;
  logic [1:0]       OpType_i;
  logic [N-1:0]     WD3_SCA_i;
  vec_t             WD3_VEC_i;
  logic [AW-1:0]    A1_i;
  logic [AW-1:0]    A2_i;
  logic [N-1:0]     RD1_SCA_o;
  logic [N-1:0]     RD2_SCA_o;
  vec_t             RD1_VEC_o;
  vec_t             RD2_VEC_o;
  logic             Mark_i;
  logic [AW-1:0]    MarkAddr_i;
  logic             MarkVec_i;
  logic             BusyS1_o;
  logic             BusyS2_o;
  logic             BusyV1_o;
  logic             BusyV2_o;

  modport master (
    output enable_i, RegFile_WE_i, A3_i, OpType_i, WD3_SCA_i, WD3_VEC_i,
    output A1_i, A2_i, Mark_i, MarkAddr_i, MarkVec_i,
    input  RD1_SCA_o, RD2_SCA_o, RD1_VEC_o, RD2_VEC_o,
    input  BusyS1_o, BusyS2_o, BusyV1_o, BusyV2_o
  );

  modport slave (
    input  enable_i, RegFile_WE_i, A3_i, OpType_i, WD3_SCA_i, WD3_VEC_i,
    input  A1_i, A2_i, Mark_i, MarkAddr_i, MarkVec_i,
    output RD1_SCA_o, RD2_SCA_o, RD1_VEC_o, RD2_VEC_o,
    output BusyS1_o, BusyS2_o, BusyV1_o, BusyV2_o
  );

endinterface

// File: rtl/reg_bank_sv_scoreboard.sv
// Pending-write scoreboard: one bit per register per file, set by issue,
// cleared by writeback commit, with a same-cycle view of clears for decode.
module reg_scoreboard
  import reg_bank_sv_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          set_i,
  input  logic          set_vec_i,
  input  logic [AW-1:0] set_addr_i,
  input  logic          clr_i,
  input  logic          clr_vec_i,
  input  logic [AW-1:0] clr_addr_i,
  input  logic [AW-1:0] rd_addr1_i,
  input  logic [AW-1:0] rd_addr2_i,
  output logic          busy_s1_o,
  output logic          busy_s2_o,
  output logic          busy_v1_o,
  output logic          busy_v2_o
);

  logic [R-1:0] pend_s_q, pend_s_d, pend_v_q, pend_v_d;
  logic [R-1:0] set_s_s, set_v_s, clr_s_s, clr_v_s;
  logic [R-1:0] view_s_s, view_v_s;

  // Decode set/clear requests into one-hot masks; scalar r0 is never marked.
  always_comb begin
    set_s_s = {R{1'b0}};
    set_v_s = {R{1'b0}};
    clr_s_s = {R{1'b0}};
    clr_v_s = {R{1'b0}};
    if (set_i && set_vec_i) begin
      set_v_s[set_addr_i] = 1'b1;
    end else if (set_i && (set_addr_i != {AW{1'b0}})) begin
      set_s_s[set_addr_i] = 1'b1;
    end else begin
      set_s_s = {R{1'b0}};
    end
    if (clr_i && clr_vec_i) begin
      clr_v_s[clr_addr_i] = 1'b1;
    end else if (clr_i) begin
      clr_s_s[clr_addr_i] = 1'b1;
    end else begin
      clr_s_s = {R{1'b0}};
    end
  end

  // Next state (set beats clear: a new producer was issued) and decode view.
  always_comb begin
    pend_s_d = (pend_s_q & ~clr_s_s) | set_s_s;
    pend_v_d = (pend_v_q & ~clr_v_s) | set_v_s;
    view_s_s = pend_s_q & ~(clr_s_s & ~set_s_s);
    view_v_s = pend_v_q & ~(clr_v_s & ~set_v_s);
    busy_s1_o = view_s_s[rd_addr1_i];
    busy_s2_o = view_s_s[rd_addr2_i];
    busy_v1_o = view_v_s[rd_addr1_i];
    busy_v2_o = view_v_s[rd_addr2_i];
  end

  // Pending-bit registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_s_q <= {R{1'b0}};
      pend_v_q <= {R{1'b0}};
    end else begin
      pend_s_q <= pend_s_d;
      pend_v_q <= pend_v_d;
    end
  end

endmodule

// File: rtl/reg_bank_sv.sv
// Scalar + vector register bank with write-through read bypass and a
// pending-write scoreboard for decode-stage RAW hazard detection.
module reg_bank_sv
  import reg_bank_sv_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  reg_bank_sv_if.slave   rb_if
);

  logic         wr_s, vec_op_s, wr_vec_s, wr_sca_s;
  logic [N-1:0] sca_q [R];
  vec_t         vec_q [R];

  // Writeback qualification; scalar r0 writes are dropped here.
  always_comb begin
    vec_op_s = is_vec_op(rb_if.OpType_i);
    wr_s     = rb_if.RegFile_WE_i & rb_if.enable_i & (rb_if.OpType_i != OP_NONE);
    wr_vec_s = wr_s & vec_op_s;
    wr_sca_s = wr_s & ~vec_op_s & (rb_if.A3_i != {AW{1'b0}});
  end

  // Scalar storage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < R; i++) sca_q[i] <= {N{1'b0}};
    end else if (wr_sca_s) begin
      sca_q[rb_if.A3_i] <= rb_if.WD3_SCA_i;
    end
  end

  // Vector storage; every lane is written together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < R; i++) vec_q[i] <= '{default: {L{1'b0}}};
    end else if (wr_vec_s) begin
      vec_q[rb_if.A3_i] <= rb_if.WD3_VEC_i;
    end
  end

  // Scalar read ports with same-cycle bypass; r0 always reads zero.
  always_comb begin
    rb_if.RD1_SCA_o = {N{1'b0}};
    rb_if.RD2_SCA_o = {N{1'b0}};
    if (rb_if.A1_i == {AW{1'b0}}) rb_if.RD1_SCA_o = {N{1'b0}};
    else if (wr_sca_s && (rb_if.A3_i == rb_if.A1_i)) rb_if.RD1_SCA_o = rb_if.WD3_SCA_i;
    else rb_if.RD1_SCA_o = sca_q[rb_if.A1_i];
    if (rb_if.A2_i == {AW{1'b0}}) rb_if.RD2_SCA_o = {N{1'b0}};
    else if (wr_sca_s && (rb_if.A3_i == rb_if.A2_i)) rb_if.RD2_SCA_o = rb_if.WD3_SCA_i;
    else rb_if.RD2_SCA_o = sca_q[rb_if.A2_i];
  end

  // Vector read ports with same-cycle bypass.
  always_comb begin
    rb_if.RD1_VEC_o = '{default: {L{1'b0}}};
    rb_if.RD2_VEC_o = '{default: {L{1'b0}}};
    if (wr_vec_s && (rb_if.A3_i == rb_if.A1_i)) rb_if.RD1_VEC_o = rb_if.WD3_VEC_i;
    else rb_if.RD1_VEC_o = vec_q[rb_if.A1_i];
    if (wr_vec_s && (rb_if.A3_i == rb_if.A2_i)) rb_if.RD2_VEC_o = rb_if.WD3_VEC_i;
    else rb_if.RD2_VEC_o = vec_q[rb_if.A2_i];
  end

  reg_scoreboard u_sb (
    .clk_i      (CLK),
    .rst_i      (RST),
    .set_i      (rb_if.Mark_i & rb_if.enable_i),
    .set_vec_i  (rb_if.MarkVec_i),
    .set_addr_i (rb_if.MarkAddr_i),
    .clr_i      (wr_s),
    .clr_vec_i  (vec_op_s),
    .clr_addr_i (rb_if.A3_i),
    .rd_addr1_i (rb_if.A1_i),
    .rd_addr2_i (rb_if.A2_i),
    .busy_s1_o  (rb_if.BusyS1_o),
    .busy_s2_o  (rb_if.BusyS2_o),
    .busy_v1_o  (rb_if.BusyV1_o),
    .busy_v2_o  (rb_if.BusyV2_o)
  );

endmodule

// File: tb/tb_reg_bank_sv.sv
// Self-checking bench for reg_bank_sv: directed scenarios plus random traffic
// checked against an array-based model of both files and the pending bits.
module tb_reg_bank_sv;
  import reg_bank_sv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  logic [N-1:0] m_sca [R];
  vec_t         m_vec [R];
  logic         m_bs  [R];
  logic         m_bv  [R];

  reg_bank_sv_if bus ();
  reg_bank_sv dut (.CLK(clk), .RST(rst), .rb_if(bus));

  always #5 clk = ~clk;

  function automatic logic m_wr();
    return bus.RegFile_WE_i && bus.enable_i && (bus.OpType_i != 2'b11);
  endfunction

  function automatic logic m_tgt_vec();
    return (bus.OpType_i == 2'b01) || (bus.OpType_i == 2'b10);
  endfunction

  function automatic logic [N-1:0] exp_sca(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_wr() && !m_tgt_vec() && bus.A3_i == a) return bus.WD3_SCA_i;
    return m_sca[a];
  endfunction

  function automatic vec_t exp_vec(input logic [4:0] a);
    if (m_wr() && m_tgt_vec() && bus.A3_i == a) return bus.WD3_VEC_i;
    return m_vec[a];
  endfunction

  function automatic logic exp_busy(input logic vf, input logic [4:0] a);
    logic pending, clearing, setting;
    pending  = vf ? m_bv[a] : m_bs[a];
    clearing = m_wr() && (m_tgt_vec() == vf) && bus.A3_i == a;
    setting  = bus.Mark_i && bus.enable_i && bus.MarkVec_i == vf && bus.MarkAddr_i == a;
    if (clearing && !setting) return 1'b0;
    return pending;
  endfunction

  // Apply this cycle's effect to the model (what the next edge will store).
  task automatic model_commit();
    if (rst) begin
      for (int i = 0; i < R; i++) begin
        m_sca[i] = '0; m_vec[i] = '0; m_bs[i] = 1'b0; m_bv[i] = 1'b0;
      end
    end else if (bus.enable_i) begin
      if (m_wr()) begin
        if (m_tgt_vec()) begin
          m_vec[bus.A3_i] = bus.WD3_VEC_i; m_bv[bus.A3_i] = 1'b0;
        end else begin
          if (bus.A3_i != 5'd0) m_sca[bus.A3_i] = bus.WD3_SCA_i;
          m_bs[bus.A3_i] = 1'b0;
        end
      end
      if (bus.Mark_i) begin
        if (bus.MarkVec_i) m_bv[bus.MarkAddr_i] = 1'b1;
        else if (bus.MarkAddr_i != 5'd0) m_bs[bus.MarkAddr_i] = 1'b1;
      end
    end
  endtask

  task automatic idle();
    bus.enable_i = 1'b1; bus.RegFile_WE_i = 1'b0; bus.A3_i = '0; bus.OpType_i = 2'b11;
    bus.WD3_SCA_i = '0; bus.WD3_VEC_i = '0; bus.A1_i = '0; bus.A2_i = '0;
    bus.Mark_i = 1'b0; bus.MarkAddr_i = '0; bus.MarkVec_i = 1'b0;
  endtask

  task automatic next_cycle();
    model_commit();
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle(); bus.RegFile_WE_i = 1'b1; bus.OpType_i = 2'b00; bus.A3_i = 5'd5; bus.WD3_SCA_i = 32'd7;
    #1 next_cycle();
    idle(); bus.RegFile_WE_i = 1'b1; bus.OpType_i = 2'b01; bus.A3_i = 5'd5;
    for (int i = 0; i < V; i++) bus.WD3_VEC_i[i] = 8'(i);
    bus.Mark_i = 1'b1; bus.MarkVec_i = 1'b1; bus.MarkAddr_i = 5'd6;
    #1 next_cycle();
    idle(); bus.A1_i = 5'd5; bus.A2_i = 5'd6;
    #1;
    tests++; if (bus.RD1_SCA_o !== 32'd7) begin fails++; $display("FAIL preload_sca got %h want %h", bus.RD1_SCA_o, 32'd7); end
    tests++; if (bus.BusyV2_o !== 1'b1) begin fails++; $display("FAIL preload_busy got %b want 1", bus.BusyV2_o); end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    tests++; if (bus.RD1_SCA_o !== 32'd0) begin fails++; $display("FAIL reset_rd1_sca got %h want 0", bus.RD1_SCA_o); end
    tests++; if (bus.RD1_VEC_o !== vec_t'(0)) begin fails++; $display("FAIL reset_rd1_vec got %h want 0", bus.RD1_VEC_o); end
    tests++; if (bus.RD2_VEC_o !== vec_t'(0)) begin fails++; $display("FAIL reset_rd2_vec got %h want 0", bus.RD2_VEC_o); end
    tests++; if ({bus.BusyS1_o, bus.BusyS2_o, bus.BusyV1_o, bus.BusyV2_o} !== 4'b0000) begin
      fails++; $display("FAIL reset_busy got %b want 0000", {bus.BusyS1_o, bus.BusyS2_o, bus.BusyV1_o, bus.BusyV2_o}); end
    next_cycle();
  endtask

  task automatic test_scalar_write();
    idle(); bus.RegFile_WE_i = 1'b1; bus.OpType_i = 2'b00; bus.A3_i = 5'd1; bus.WD3_SCA_i = 32'd2; bus.A1_i = 5'd1;
    #1;
    tests++; if (bus.RD1_SCA_o !== 32'd2) begin fails++; $display("FAIL sca_bypass got %h want 2", bus.RD1_SCA_o); end
    next_cycle();
    idle(); bus.A1_i = 5'd1;
    #1;
    tests++; if (bus.RD1_SCA_o !== 32'd2) begin fails++; $display("FAIL sca_stored got %h want 2", bus.RD1_SCA_o); end
    tests++; if (bus.RD1_VEC_o !== vec_t'(0)) begin fails++; $display("FAIL sca_vec_untouched got %h want 0", bus.RD1_VEC_o); end
    next_cycle();
  endtask

  task automatic test_vector_write();
    idle(); bus.RegFile_WE_i = 1'b1; bus.OpType_i = 2'b01; bus.A3_i = 5'd1; bus.A2_i = 5'd1;
    for (int i = 0; i < V; i++) bus.WD3_VEC_i[i] = 8'(i * 2);
    #1;
    tests++; if (bus.RD2_VEC_o[19] !== 8'd38) begin fails++; $display("FAIL vec_bypass_lane19 got %h want %h", bus.RD2_VEC_o[19], 8'd38); end
    next_cycle();
    idle(); bus.RegFile_WE_i = 1'b1; bus.OpType_i = 2'b11; bus.A3_i = 5'd1; bus.A2_i = 5'd1;
    for (int i = 0; i < V; i++) bus.WD3_VEC_i[i] = 8'hAA;
    #1;
    tests++; if (bus.RD2_VEC_o[19] !== 8'd38) begin fails++; $display("FAIL vec_opnone_bypass got %h want %h", bus.RD2_VEC_o[19], 8'd38); end
    next_cycle();
    idle(); bus.A2_i = 5'd1; bus.OpType_i = 2'b10;
    #1;
    tests++; if (bus.RD2_VEC_o !== m_vec[1] || bus.RD2_VEC_o[7] !== 8'd14) begin
      fails++; $display("FAIL vec_opnone_stored got %h want %h", bus.RD2_VEC_o, m_vec[1]); end
    next_cycle();
  endtask

  task automatic test_reg0();
    vec_t d;
    idle(); bus.RegFile_WE_i = 1'b1; bus.OpType_i = 2'b00; bus.A3_i = 5'd0; bus.WD3_SCA_i = 32'hFFFF_FFFF;
    #1;
    tests++; if (bus.RD1_SCA_o !== 32'd0) begin fails++; $display("FAIL r0_bypass got %h want 0", bus.RD1_SCA_o); end
    next_cycle();
    idle(); #1;
    tests++; if (bus.RD1_SCA_o !== 32'd0) begin fails++; $display("FAIL r0_stored got %h want 0", bus.RD1_SCA_o); end
    for (int i = 0; i < V; i++) d[i] = 8'(i + 1);
    bus.RegFile_WE_i = 1'b1; bus.OpType_i = 2'b10; bus.A3_i = 5'd0; bus.WD3_VEC_i = d;
    #1;
    tests++; if (bus.RD1_VEC_o !== d) begin fails++; $display("FAIL v0_bypass got %h want %h", bus.RD1_VEC_o, d); end
    next_cycle();
    idle(); #1;
    tests++; if (bus.RD1_VEC_o !== d) begin fails++; $display("FAIL v0_stored got %h want %h", bus.RD1_VEC_o, d); end
    next_cycle();
  endtask

  task automatic test_scoreboard();
    idle(); bus.Mark_i = 1'b1; bus.MarkVec_i = 1'b1; bus.MarkAddr_i = 5'd3; bus.A1_i = 5'd3;
    #1;
    tests++; if (bus.BusyV1_o !== 1'b0) begin fails++; $display("FAIL sb_mark_same_cycle got %b want 0", bus.BusyV1_o); end
    next_cycle();
    idle(); bus.A1_i = 5'd3; #1;
    tests++; if (bus.BusyV1_o !== 1'b1) begin fails++; $display("FAIL sb_busyv1 got %b want 1", bus.BusyV1_o); end
    tests++; if (bus.BusyS1_o !== 1'b0) begin fails++; $display("FAIL sb_busys1 got %b want 0", bus.BusyS1_o); end
    bus.RegFile_WE_i = 1'b1; bus.OpType_i = 2'b01; bus.A3_i = 5'd3; #1;
    tests++; if (bus.BusyV1_o !== 1'b0) begin fails++; $display("FAIL sb_clear_bypass got %b want 0", bus.BusyV1_o); end
    next_cycle();
    idle(); bus.A1_i = 5'd3; #1;
    tests++; if (bus.BusyV1_o !== 1'b0) begin fails++; $display("FAIL sb_cleared got %b want 0", bus.BusyV1_o); end
    bus.RegFile_WE_i = 1'b1; bus.OpType_i = 2'b01; bus.A3_i = 5'd3;
    bus.Mark_i = 1'b1; bus.MarkVec_i = 1'b1; bus.MarkAddr_i = 5'd3;
    next_cycle();
    idle(); bus.A1_i = 5'd3; #1;
    tests++; if (bus.BusyV1_o !== 1'b1) begin fails++; $display("FAIL sb_set_wins got %b want 1", bus.BusyV1_o); end
    next_cycle();
  endtask

  task automatic test_stall();
    idle(); bus.enable_i = 1'b0; bus.RegFile_WE_i = 1'b1; bus.OpType_i = 2'b00; bus.A3_i = 5'd2;
    bus.WD3_SCA_i = 32'd9; bus.Mark_i = 1'b1; bus.MarkVec_i = 1'b0; bus.MarkAddr_i = 5'd4; bus.A1_i = 5'd2;
    #1;
    tests++; if (bus.RD1_SCA_o !== m_sca[2]) begin fails++; $display("FAIL stall_no_bypass got %h want %h", bus.RD1_SCA_o, m_sca[2]); end
    next_cycle();
    idle(); bus.A1_i = 5'd2; bus.A2_i = 5'd4; #1;
    tests++; if (bus.RD1_SCA_o !== 32'd0) begin fails++; $display("FAIL stall_r2 got %h want 0", bus.RD1_SCA_o); end
    tests++; if (bus.BusyS2_o !== 1'b0) begin fails++; $display("FAIL stall_busy_r4 got %b want 0", bus.BusyS2_o); end
    next_cycle();
  endtask

  task automatic test_random();
    logic [N-1:0] es1, es2;
    vec_t ev1, ev2;
    logic [3:0] eb;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      bus.enable_i = ($urandom_range(0, 9) != 0);
      bus.RegFile_WE_i = $urandom_range(0, 1);
      bus.OpType_i = 2'($urandom_range(0, 3));
      bus.A3_i = 5'($urandom_range(0, 7));
      bus.WD3_SCA_i = $urandom;
      for (int i = 0; i < V; i++) bus.WD3_VEC_i[i] = 8'($urandom);
      bus.A1_i = 5'($urandom_range(0, 7));
      bus.A2_i = 5'($urandom_range(0, 7));
      bus.Mark_i = $urandom_range(0, 1);
      bus.MarkVec_i = $urandom_range(0, 1);
      bus.MarkAddr_i = 5'($urandom_range(0, 7));
      #1;
      es1 = exp_sca(bus.A1_i); es2 = exp_sca(bus.A2_i);
      ev1 = exp_vec(bus.A1_i); ev2 = exp_vec(bus.A2_i);
      eb = {exp_busy(1'b0, bus.A1_i), exp_busy(1'b0, bus.A2_i), exp_busy(1'b1, bus.A1_i), exp_busy(1'b1, bus.A2_i)};
      tests++; if (bus.RD1_SCA_o !== es1) begin fails++; $display("FAIL rnd_rd1_sca c=%0d got %h want %h", c, bus.RD1_SCA_o, es1); end
      tests++; if (bus.RD2_SCA_o !== es2) begin fails++; $display("FAIL rnd_rd2_sca c=%0d got %h want %h", c, bus.RD2_SCA_o, es2); end
      tests++; if (bus.RD1_VEC_o !== ev1) begin fails++; $display("FAIL rnd_rd1_vec c=%0d got %h want %h", c, bus.RD1_VEC_o, ev1); end
      tests++; if (bus.RD2_VEC_o !== ev2) begin fails++; $display("FAIL rnd_rd2_vec c=%0d got %h want %h", c, bus.RD2_VEC_o, ev2); end
      tests++; if ({bus.BusyS1_o, bus.BusyS2_o, bus.BusyV1_o, bus.BusyV2_o} !== eb) begin
        fails++; $display("FAIL rnd_busy c=%0d got %b want %b", c, {bus.BusyS1_o, bus.BusyS2_o, bus.BusyV1_o, bus.BusyV2_o}, eb); end
      next_cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    next_cycle();
    next_cycle();
    rst = 1'b0;
    test_reset();
    test_scalar_write();
    test_vector_write();
    test_reg0();
    test_scoreboard();
    test_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
